lease_table_loader: RTL and testbench

Sequencer that programs the lease policy controller's lease lookup table and default-lease configuration register from a 32-bit valid/ready word stream, such as a host or DMA reading a lease image from memory. It sits between the stream source and the policy controller's `con_wren`/`llt_wren`/`llt_addr`/`llt_data` ports. It holds `busy_o` while loading so the cache controller can stall core requests until the table is consistent.

---
 rtl/lease_table_loader.sv | 79 +++++++
 tb/tb_lease_table_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/lease_table_loader.sv
// lease_table_loader: streams a lease image into the policy controller's config register and four LLTs
module lease_table_loader #(
   parameter int N_ENTRIES     = 128,
   parameter int BW_ENTRIES    = $clog2(N_ENTRIES),
   parameter int BW_ADDR_SPACE = BW_ENTRIES + 2
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic                     start_i,
   input  logic                     s_valid_i,
   input  logic [31:0]              s_data_i,
   output logic                     s_ready_o,
   output logic                     con_wren_o,
   output logic                     llt_wren_o,
   output logic [BW_ADDR_SPACE-1:0] llt_addr_o,
   output logic [31:0]              llt_data_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     error_o
);
   typedef enum logic [2:0] {IDLE, HEADER, DEFAULT, TABLE, FINISH} state_t;
   state_t state, state_nx;
   logic [BW_ENTRIES:0]   count;
   logic [BW_ENTRIES-1:0] index;
   logic [1:0]            tbl;
   logic                  accept, hdr_bad, idx_last;
   assign s_ready_o = (state == HEADER) || (state == DEFAULT) || (state == TABLE);
   assign accept    = s_valid_i & s_ready_o;
   assign hdr_bad   = {16'd0, s_data_i[15:0]} > $unsigned(N_ENTRIES);
   assign idx_last  = {1'b0, index} == count - (BW_ENTRIES+1)'(1);
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start_i ? HEADER : IDLE;
         HEADER:  state_nx = accept ? (hdr_bad ? IDLE : DEFAULT) : HEADER;
         DEFAULT: state_nx = accept ? (count == '0 ? FINISH : TABLE) : DEFAULT;
         TABLE:   state_nx = (accept && tbl == 2'd3 && idx_last) ? FINISH : TABLE;
         FINISH:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state      <= IDLE;
         count      <= '0;
         index      <= '0;
         tbl        <= '0;
         con_wren_o <= 1'b0;
         llt_wren_o <= 1'b0;
         llt_addr_o <= '0;
         llt_data_o <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         error_o    <= 1'b0;
      end else begin
         state      <= state_nx;
         busy_o     <= state_nx != IDLE;
         done_o     <= state == FINISH;
         error_o    <= accept && state == HEADER && hdr_bad;
         con_wren_o <= accept && state == DEFAULT;
         llt_wren_o <= accept && state == TABLE;
         if (accept && state == HEADER && !hdr_bad)
            count <= s_data_i[BW_ENTRIES:0];
         if (accept && state == DEFAULT) begin
            index      <= '0;
            tbl        <= '0;
            llt_addr_o <= '0;
            llt_data_o <= s_data_i;
         end
         // the table counter saturates at 3; FINISH follows the last word
         if (accept && state == TABLE) begin
            llt_addr_o <= BW_ADDR_SPACE'({tbl, index});
            llt_data_o <= s_data_i;
            index      <= idx_last ? '0 : index + 1'b1;
            tbl        <= (idx_last && tbl != 2'd3) ? tbl + 2'd1 : tbl;
         end
      end
   end
endmodule

// File: tb/tb_lease_table_loader.sv
// tb_lease_table_loader: directed loads checked against a scoreboard of expected writes
module tb_lease_table_loader;
   localparam int N  = 128;
   localparam int AW = $clog2(N) + 2;
   logic          clk = 1'b0, rst = 1'b1, start = 1'b0, s_valid = 1'b0;
   logic [31:0]   s_data = '0;
   logic          s_ready, con_wren, llt_wren, busy, done, error;
   logic [AW-1:0] llt_addr;
   logic [31:0]   llt_data;
   typedef struct {bit con; logic [AW-1:0] addr; logic [31:0] data;} wr_t;
   wr_t  exp_q[$];
   int   n_assert = 0, n_fail = 0, n_done = 0, n_err = 0, n_llt = 0, n_con = 0;
   logic prev_acc = 1'b0;
   lease_table_loader #(.N_ENTRIES(N)) dut (
      .clock_i(clk), .reset_i(rst), .start_i(start), .s_valid_i(s_valid), .s_data_i(s_data),
      .s_ready_o(s_ready), .con_wren_o(con_wren), .llt_wren_o(llt_wren), .llt_addr_o(llt_addr),
      .llt_data_o(llt_data), .busy_o(busy), .done_o(done), .error_o(error)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   always @(negedge clk) begin
      if (con_wren || llt_wren) begin
         chk("strobe_after_accept", {63'd0, prev_acc}, 64'd1);
         chk("strobe_exclusive", {63'd0, con_wren & llt_wren}, 64'd0);
         chk("write_expected", {63'd0, exp_q.size() > 0}, 64'd1);
         if (exp_q.size() > 0) begin
            chk("wr_kind", {63'd0, con_wren}, {63'd0, exp_q[0].con});
            chk("wr_addr", 64'(llt_addr), 64'(exp_q[0].addr));
            chk("wr_data", 64'(llt_data), 64'(exp_q[0].data));
            void'(exp_q.pop_front());
         end
         n_con += int'(con_wren);
         n_llt += int'(llt_wren);
      end
      n_done  += int'(done);
      n_err   += int'(error);
      prev_acc = s_valid & s_ready;
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [31:0] w, input bit stall);
      int b = 0;
      if (stall) while ($urandom_range(0, 2) == 0) tick();
      s_valid = 1'b1;
      s_data  = w;
      while (!s_ready && b < 20) begin
         tick();
         b++;
      end
      chk("ready_timeout", 64'(b < 20), 64'd1);
      tick();
      s_valid = 1'b0;
   endtask
   task automatic start_load();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("ready_after_start", 64'(s_ready), 64'd1);
   endtask
   task automatic hdr_def(input int c, input logic [31:0] dflt, input bit stall);
      send({16'hABCD, 16'(c)}, stall);
      exp_q.push_back('{con: 1'b1, addr: '0, data: dflt});
      send(dflt, stall);
   endtask
   task automatic tword(input int t, input int i, input logic [31:0] w, input bit stall);
      exp_q.push_back('{con: 1'b0, addr: AW'(t * N + i), data: w});
      send(w, stall);
   endtask
   task automatic wait_done();
      int b = 0;
      chk("busy_before_done", 64'(busy), 64'd1);
      while (!done && b < 50) begin
         tick();
         b++;
      end
      chk("done_pulse", 64'(done), 64'd1);
      chk("busy_at_done", 64'(busy), 64'd0);
      chk("ready_at_done", 64'(s_ready), 64'd0);
      tick();
      chk("done_single", 64'(done), 64'd0);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask
   task automatic full_load(input int c, input bit stall, input bit start_mid);
      start_load();
      hdr_def(c, $urandom, stall);
      for (int t = 0; t < 4; t++)
         for (int i = 0; i < c; i++) begin
            start = start_mid && t == 1 && i == 0;
            tword(t, i, $urandom, stall);
            start = 1'b0;
         end
      wait_done();
   endtask
   initial begin
      logic [31:0] t1 [8] = '{32'h100, 32'h104, 32'd5, 32'd6, 32'd1, 32'd2, 32'd256, 32'd128};
      int d0, l0, c0, e0;
      repeat (3) tick();
      chk("rst_outputs", {s_ready, con_wren, llt_wren, busy, done, error}, 6'd0);
      chk("rst_addr_data", {llt_addr, llt_data}, '0);
      rst = 1'b0;
      tick();
      // normal load
      start_load();
      hdr_def(2, 7, 1'b0);
      for (int k = 0; k < 8; k++) tword(k / 2, k % 2, t1[k], 1'b0);
      wait_done();
      chk("t1_done_count", 64'(n_done), 64'd1);
      chk("t1_llt_count", 64'(n_llt), 64'd8);
      chk("t1_con_count", 64'(n_con), 64'd1);
      // zero entries
      l0 = n_llt;
      c0 = n_con;
      start_load();
      hdr_def(0, 3, 1'b0);
      wait_done();
      chk("t2_llt_count", 64'(n_llt - l0), 64'd0);
      chk("t2_con_count", 64'(n_con - c0), 64'd1);
      // oversize header
      l0 = n_llt;
      c0 = n_con;
      e0 = n_err;
      start_load();
      send({16'h0, 16'(N + 1)}, 1'b0);
      chk("t3_error", 64'(error), 64'd1);
      chk("t3_busy", 64'(busy), 64'd0);
      chk("t3_ready", 64'(s_ready), 64'd0);
      tick();
      chk("t3_error_single", 64'(error), 64'd0);
      chk("t3_err_count", 64'(n_err - e0), 64'd1);
      chk("t3_no_writes", 64'(n_llt + n_con - l0 - c0), 64'd0);
      // full table with stalls
      l0 = n_llt;
      full_load(N, 1'b1, 1'b0);
      chk("t4_llt_count", 64'(n_llt - l0), 64'(4 * N));
      chk("t4_last_addr", 64'(llt_addr), 64'(4 * N - 1));
      // reset mid-load
      d0 = n_done;
      start_load();
      hdr_def(8, 32'h55, 1'b0);
      for (int i = 0; i < 5; i++) tword(0, i, $urandom, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst_outputs", {s_ready, con_wren, llt_wren, busy, done, error}, 6'd0);
      chk("t5_rst_addr_data", {llt_addr, llt_data}, '0);
      repeat (4) tick();
      chk("t5_no_done", 64'(n_done - d0), 64'd0);
      chk("t5_queue", 64'(exp_q.size()), 64'd0);
      full_load(4, 1'b0, 1'b0);
      chk("t5_reload_done", 64'(n_done - d0), 64'd1);
      // start while busy
      d0 = n_done;
      full_load(3, 1'b0, 1'b1);
      chk("t6_done_count", 64'(n_done - d0), 64'd1);
      chk("t6_idle_after", 64'(busy), 64'd0);
      // simultaneous start and reset
      start = 1'b1;
      rst   = 1'b1;
      tick();
      start = 1'b0;
      rst   = 1'b0;
      chk("t7_reset_wins_busy", 64'(busy), 64'd0);
      chk("t7_reset_wins_ready", 64'(s_ready), 64'd0);
      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
